spm_wb_arbiter: RTL
===================

Name: spm_wb_arbiter

Overview:
Shares the single bridge-facing writeback bus between NUM_BANKS scratchpad read controllers. It watches each controller's kernel_fin and grants writeback to one bank at a time in round-robin order by pulsing that bank's wb_enable. It muxes the granted bank's dbus onto the bridge, routes ack back to that bank only, and tracks per-bank completion, with a watchdog on stalled transfers.

Parameters:
NUM_BANKS, 4, number of read controllers sharing the bus (≥2)
BANK_SIZE, 512, words per bank; sets num_words width $clog2(BANK_SIZE)
DBUS_WIDTH, 32, bridge data width
TIMEOUT_CYC, 1024, max cycles in a transfer without a beat before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (block held in reset while rst==0)
wb_enable  in  1  CSR: writeback globally permitted
num_words  in  $clog2(BANK_SIZE)  CSR: words per bank, the same value given to the controllers
clear_done  in  1  pulse: clears done_mask and err
kernel_fin_i  in  NUM_BANKS  per-bank kernel_fin from the controllers
wb_enable_o  out  NUM_BANKS  per-bank wb_enable to the controllers
dbus_in  in  NUM_BANKS×DBUS_WIDTH  per-bank dbus_out
dbus_valid_in  in  NUM_BANKS  per-bank dbus_valid
ack_o  out  NUM_BANKS  per-bank ack
ack_in  in  1  ack from the bridge
dbus_out  out  DBUS_WIDTH  bus to the bridge
dbus_valid_out  out  1  valid to the bridge
grant_id  out  $clog2(NUM_BANKS)  currently or last granted bank
busy  out  1  state != ARB_IDLE
done_mask  out  NUM_BANKS  banks whose writeback has finished
all_done  out  1  &done_mask
err  out  1  sticky watchdog error

Behaviour:
- Reset (rst==0, async): state=ARB_IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, wd_cnt=0, done_mask=0, err=0. All outputs are 0.
- Eligibility: elig[i] = kernel_fin_i[i] & ~done_mask[i].
- ARB_IDLE: if wb_enable & |elig, pick the first eligible bank at or after rr_ptr, wrapping modulo NUM_BANKS. Register it as grant_id, then go to ARB_GRANT. Otherwise stay in ARB_IDLE.
- ARB_GRANT: wb_enable_o[grant_id]=1 for exactly this one cycle; clear beat_cnt and wd_cnt; go to ARB_XFER. Latency is: eligible sampled in cycle N, pulse in cycle N+1, ARB_XFER from cycle N+2.
- ARB_XFER:
  - A beat is any cycle with dbus_valid_in[grant_id]=1.
  - On a beat: beat_cnt++ and wd_cnt=0.
  - On a beat with beat_cnt==num_words, the transfer is complete. A transfer is num_words+1 beats: a magic header plus the words. Set done_mask[grant_id], set rr_ptr=(grant_id+1) mod NUM_BANKS, and go to ARB_IDLE.
  - On a cycle without a beat: wd_cnt++. If wd_cnt reaches TIMEOUT_CYC-1, go to ARB_ERR.
- ARB_ERR (one cycle): set err, set done_mask[grant_id] so the stuck bank is not regranted, advance rr_ptr, go to ARB_IDLE.
- Muxing (combinational):
  - In ARB_XFER: dbus_out=dbus_in[grant_id], dbus_valid_out=dbus_valid_in[grant_id], ack_o[grant_id]=ack_in.
  - In every other state, and for every ungranted bank: all three are 0.
- Width rules:
  - beat_cnt has the width of num_words, so num_words=BANK_SIZE-1 gives BANK_SIZE beats without overflow.
  - wd_cnt is $clog2(TIMEOUT_CYC) bits.
  - num_words=0 gives a single beat (header only).
- wb_enable deasserted mid-transfer: the current transfer completes normally; no new grant is issued until it reasserts.
- clear_done arriving in the same cycle as a completion: the completion's done bit wins for that bank; err is cleared. clear_done never aborts an active transfer.
- kernel_fin_i of the granted bank falling during ARB_XFER is expected and ignored.
- Bank requests arriving while busy are held by level and considered at the next ARB_IDLE.
- num_words must be stable while busy; a change mid-transfer is undefined.

Decomposition:
- spm_types package:
  - enum spm_wb_arb_fsm_t {arb_idle, arb_grant, arb_xfer, arb_err}, placed next to spm_sram_read_fsm_t.
  - The bank-count and width localparams.
- One sub-module: spm_rr_pick. It is combinational: takes the request vector and rr_ptr, returns a one-hot grant and its index, with wraparound.

Test Plan:
- Single bank, NUM_BANKS=4, num_words=3: kernel_fin_i=0001 with wb_enable=1 → wb_enable_o=0001 for exactly 1 cycle. Then 4 beats appear on dbus_out, including header 0xECEBCAFE. Then done_mask=0001, all_done=0, busy drops.
- Contention: kernel_fin_i=0101 in the same cycle → grant order is bank 0 then bank 2, and ack_o never goes to bank 2 during bank 0's transfer. After clear_done with rr_ptr=3, reassert 0101 → order is 0, then 2 (wrap). All four banks finished → all_done=1.
- Watchdog, TIMEOUT_CYC=16: grant bank 1 and never assert dbus_valid_in → err=1 after 16 idle cycles in ARB_XFER. done_mask[1]=1, the bus is released, and the next eligible bank is granted.
- num_words=0 → one beat completes the transfer. Also: wb_enable dropped mid-transfer → the transfer finishes, and no new grant appears until wb_enable=1.
- Async reset asserted mid-ARB_XFER (not on a clock edge) → all outputs 0 immediately, done_mask=0. After release, a pending kernel_fin_i is regranted starting from bank 0.

Source files
------------

// File: rtl/spm_types_pkg.sv
// Shared types and default sizing for the scratchpad memory subsystem.
// The arbiter and its round-robin picker import this package.
package spm_types;

    localparam int SPM_NUM_BANKS   = 4;
    localparam int SPM_BANK_SIZE   = 512;
    localparam int SPM_DBUS_WIDTH  = 32;
    localparam int SPM_TIMEOUT_CYC = 1024;
    localparam int SPM_NUM_WORDS_W = $clog2(SPM_BANK_SIZE);
    localparam int SPM_BANK_IDX_W  = $clog2(SPM_NUM_BANKS);

    // First beat of every bank writeback, sent ahead of the data words.
    localparam logic [31:0] SPM_WB_MAGIC = 32'hECEBCAFE;

    typedef enum logic [2:0] {
        sram_idle,
        sram_wait_wb,
        sram_header,
        sram_read,
        sram_done
    } spm_sram_read_fsm_t;

    typedef enum logic [1:0] {
        arb_idle,
        arb_grant,
        arb_xfer,
        arb_err
    } spm_wb_arb_fsm_t;

endpackage

// File: rtl/spm_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr,
// wrapping modulo NUM_BANKS; returns one-hot grant and its index.
module spm_rr_pick
    import spm_types::*;
#(
    parameter int NUM_BANKS = SPM_NUM_BANKS,
    parameter int IDX_W     = $clog2(NUM_BANKS)
) (
    input  logic [NUM_BANKS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_BANKS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_valid
);

    logic [IDX_W-1:0] w_slot;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_slot  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            w_slot = IDX_W'((int'(i_ptr) + k) % NUM_BANKS);
            if (!w_found && i_req[w_slot]) begin
                w_found         = 1'b1;
                o_grant[w_slot] = 1'b1;
                o_idx           = w_slot;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/spm_wb_arbiter.sv
// Round-robin arbiter sharing the bridge writeback bus between scratchpad
// read controllers, with per-bank completion tracking and a stall watchdog.
module spm_wb_arbiter
    import spm_types::*;
#(
    parameter int NUM_BANKS   = SPM_NUM_BANKS,
    parameter int BANK_SIZE   = SPM_BANK_SIZE,
    parameter int DBUS_WIDTH  = SPM_DBUS_WIDTH,
    parameter int TIMEOUT_CYC = SPM_TIMEOUT_CYC
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wb_enable,
    input  logic [$clog2(BANK_SIZE)-1:0]         num_words,
    input  logic                                 clear_done,
    input  logic [NUM_BANKS-1:0]                 kernel_fin_i,
    output logic [NUM_BANKS-1:0]                 wb_enable_o,
    input  logic [NUM_BANKS-1:0][DBUS_WIDTH-1:0] dbus_in,
    input  logic [NUM_BANKS-1:0]                 dbus_valid_in,
    output logic [NUM_BANKS-1:0]                 ack_o,
    input  logic                                 ack_in,
    output logic [DBUS_WIDTH-1:0]                dbus_out,
    output logic                                 dbus_valid_out,
    output logic [$clog2(NUM_BANKS)-1:0]         grant_id,
    output logic                                 busy,
    output logic [NUM_BANKS-1:0]                 done_mask,
    output logic                                 all_done,
    output logic                                 err
);

    localparam int IDX_W = $clog2(NUM_BANKS);
    localparam int NW_W  = $clog2(BANK_SIZE);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);

    spm_wb_arb_fsm_t        r_state;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_grant_id;
    logic [NW_W-1:0]        r_beat_cnt;
    logic [WD_W-1:0]        r_wd_cnt;
    logic [NUM_BANKS-1:0]   r_done_mask;
    logic [NUM_BANKS-1:0]   r_wb_pulse;
    logic                   r_err;

    logic [NUM_BANKS-1:0]   w_elig;
    logic [NUM_BANKS-1:0]   w_pick_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_beat;
    logic [IDX_W-1:0]       w_next_ptr;

    assign w_elig     = kernel_fin_i & ~r_done_mask;
    assign w_beat     = (r_state == arb_xfer) && dbus_valid_in[r_grant_id];
    assign w_next_ptr = (r_grant_id == IDX_W'(NUM_BANKS - 1)) ? '0 : r_grant_id + 1'b1;

    spm_rr_pick #(
        .NUM_BANKS (NUM_BANKS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .i_req   (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // clear_done is applied first so a same-cycle completion or error re-sets its bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= arb_idle;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_beat_cnt  <= '0;
            r_wd_cnt    <= '0;
            r_done_mask <= '0;
            r_wb_pulse  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_wb_pulse <= '0;
            if (clear_done) begin
                r_done_mask <= '0;
                r_err       <= 1'b0;
            end
            case (r_state)
                arb_idle: begin
                    if (wb_enable && w_pick_valid) begin
                        r_grant_id <= w_pick_idx;
                        r_wb_pulse <= w_pick_grant;
                        r_state    <= arb_grant;
                    end
                end
                arb_grant: begin
                    r_beat_cnt <= '0;
                    r_wd_cnt   <= '0;
                    r_state    <= arb_xfer;
                end
                arb_xfer: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        r_wd_cnt   <= '0;
                        if (r_beat_cnt == num_words) begin
                            r_done_mask[r_grant_id] <= 1'b1;
                            r_rr_ptr                <= w_next_ptr;
                            r_state                 <= arb_idle;
                        end
                    end else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                        r_state <= arb_err;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                arb_err: begin
                    r_err                   <= 1'b1;
                    r_done_mask[r_grant_id] <= 1'b1;
                    r_rr_ptr                <= w_next_ptr;
                    r_state                 <= arb_idle;
                end
                default: r_state <= arb_idle;
            endcase
        end
    end

    // Only the granted bank sees the bridge, and only while data is flowing.
    always_comb begin
        dbus_out       = '0;
        dbus_valid_out = 1'b0;
        ack_o          = '0;
        if (r_state == arb_xfer) begin
            dbus_out          = dbus_in[r_grant_id];
            dbus_valid_out    = dbus_valid_in[r_grant_id];
            ack_o[r_grant_id] = ack_in;
        end
    end

    assign wb_enable_o = r_wb_pulse;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != arb_idle);
    assign done_mask   = r_done_mask;
    assign all_done    = &r_done_mask;
    assign err         = r_err;

endmodule
